fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline: owns the PC, issues requests to the instruction memory/cache, and delivers one instruction per cycle into the IF/ID boundary. It consumes the hazard unit's stall (`hold`) and flush (`redirect_en`) decisions and the resolved branch/jump target. It absorbs variable memory latency, late returns during stalls, and halt.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/fetch_skid.sv | 34 +++
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Types and constants shared by the fetch, decode and hazard stages.
package pipe_pkg;

  typedef logic [15:0] word_t;

  localparam word_t      NOP_INSTR = 16'h0800;
  localparam logic [4:0] HALT_OPC  = 5'b00000;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DISCARD,
    HALTED
  } fetch_state_t;

  function automatic logic is_halt(input word_t instr);
    return instr[15:11] == HALT_OPC;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding slot for an instruction that returns while the pipeline is stalled.
module fetch_skid
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [15:0] load_instr,
  input  logic [15:0] load_pc_plus2,
  output logic        valid,
  output logic [15:0] instr,
  output logic [15:0] pc_plus2
);

  // A flush beats a simultaneous load so no stale instruction survives a redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      instr    <= NOP_INSTR;
      pc_plus2 <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= load_instr;
      pc_plus2 <= load_pc_plus2;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory and feeds IF/ID.
module fetch_unit
  import pipe_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc_plus2,
  output logic        if_valid,
  output logic        halted
);

  fetch_state_t state, state_nxt;
  word_t        pc, pc_nxt;
  word_t        pend_addr, pend_addr_nxt;
  word_t        instr_nxt, pc_plus2_nxt;
  logic         valid_nxt, halted_nxt;
  logic         rd, deliver;

  logic         sb_valid, sb_load, sb_drain, sb_clear;
  word_t        sb_instr, sb_pc_plus2;

  fetch_skid u_skid (
    .clk           (clk),
    .rst           (rst),
    .load          (sb_load),
    .drain         (sb_drain),
    .clear         (sb_clear),
    .load_instr    (imem_data),
    .load_pc_plus2 (pc + 16'd2),
    .valid         (sb_valid),
    .instr         (sb_instr),
    .pc_plus2      (sb_pc_plus2)
  );

  // After a redirect the PC already holds the target, so an outstanding access keeps its own address.
  assign imem_addr = (state == WAIT || state == DISCARD) ? pend_addr : pc;
  assign imem_rd   = rd && !rst;

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    pend_addr_nxt = pend_addr;
    instr_nxt     = if_instr;
    pc_plus2_nxt  = if_pc_plus2;
    valid_nxt     = if_valid;
    halted_nxt    = halted;
    sb_load       = 1'b0;
    sb_drain      = 1'b0;
    sb_clear      = 1'b0;
    rd            = 1'b0;
    deliver       = 1'b0;

    case (state)
      REQ: begin
        rd = !hold && !sb_valid;
        if (rd && imem_done) deliver = 1'b1;
        else if (rd)         state_nxt = WAIT;
      end
      WAIT: begin
        rd = 1'b1;
        if (imem_done) begin
          deliver   = 1'b1;
          state_nxt = REQ;
        end
      end
      DISCARD: begin
        rd = 1'b1;
        if (imem_done) state_nxt = REQ;
      end
      HALTED: rd = 1'b0;
      default: state_nxt = REQ;
    endcase

    if (rd) pend_addr_nxt = imem_addr;

    if (deliver) begin
      pc_nxt = pc + 16'd2;
      if (!hold) begin
        instr_nxt    = imem_data;
        pc_plus2_nxt = pc + 16'd2;
        valid_nxt    = 1'b1;
        if (is_halt(imem_data)) begin
          state_nxt  = HALTED;
          halted_nxt = 1'b1;
        end
      end else begin
        sb_load = 1'b1;
      end
    end else if (!hold) begin
      if (state == REQ && sb_valid) begin
        instr_nxt    = sb_instr;
        pc_plus2_nxt = sb_pc_plus2;
        valid_nxt    = 1'b1;
        sb_drain     = 1'b1;
        if (is_halt(sb_instr)) begin
          state_nxt  = HALTED;
          halted_nxt = 1'b1;
        end
      end else begin
        instr_nxt = NOP_INSTR;
        valid_nxt = 1'b0;
      end
    end

    // Redirect overrides stall, delivery and halt; any data returning this cycle is dropped.
    if (redirect_en) begin
      pc_nxt     = redirect_pc & 16'hFFFE;
      instr_nxt  = NOP_INSTR;
      valid_nxt  = 1'b0;
      halted_nxt = 1'b0;
      sb_load    = 1'b0;
      sb_drain   = 1'b0;
      sb_clear   = 1'b1;
      state_nxt  = (rd && !imem_done) ? DISCARD : REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= REQ;
      pc          <= RESET_PC;
      pend_addr   <= RESET_PC;
      if_instr    <= NOP_INSTR;
      if_pc_plus2 <= '0;
      if_valid    <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      pend_addr   <= pend_addr_nxt;
      if_instr    <= instr_nxt;
      if_pc_plus2 <= pc_plus2_nxt;
      if_valid    <= valid_nxt;
      halted      <= halted_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: hits, miss, stall skid, redirect, halt and PC wrap.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data;
  logic        imem_done;
  logic [15:0] if_instr;
  logic [15:0] if_pc_plus2;
  logic        if_valid;
  logic        halted;

  int          checks;
  int          errors;
  logic [15:0] halt_addr;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .hold        (hold),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .imem_data   (imem_data),
    .imem_done   (imem_done),
    .if_instr    (if_instr),
    .if_pc_plus2 (if_pc_plus2),
    .if_valid    (if_valid),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: bit 15 set keeps ordinary words clear of the HALT opcode.
  function automatic logic [15:0] mem_word(input logic [15:0] a, input logic [15:0] h);
    return (a == h) ? 16'h0000 : (16'h8000 | a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd: got %b expected 0", imem_rd); end
    checks++; if (if_instr !== 16'h0800) begin errors++; $display("[TB] FAIL reset_instr: got %h expected 0800", if_instr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", if_valid); end
    checks++; if (if_pc_plus2 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pc2: got %h expected 0000", if_pc_plus2); end
    checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %b expected 0", halted); end
    rst = 1'b0;
    #1;
    checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL first_req: got rd=%b addr=%h expected rd=1 addr=0000", imem_rd, imem_addr); end
  endtask

  task automatic test_hits();
    logic [15:0] exp_addr;
    for (int i = 0; i < 2; i++) begin
      exp_addr  = 16'(2 * i);
      imem_done = 1'b1;
      imem_data = mem_word(imem_addr, halt_addr);
      checks++; if (imem_addr !== exp_addr) begin errors++; $display("[TB] FAIL hit_addr: got %h expected %h", imem_addr, exp_addr); end
      tick();
      checks++; if (if_instr !== (16'h8000 | exp_addr)) begin errors++; $display("[TB] FAIL hit_instr: got %h expected %h", if_instr, 16'h8000 | exp_addr); end
      checks++; if (if_pc_plus2 !== exp_addr + 16'd2 || if_valid !== 1'b1) begin errors++; $display("[TB] FAIL hit_pc2: got %h/%b expected %h/1", if_pc_plus2, if_valid, exp_addr + 16'd2); end
    end
    imem_done = 1'b0;
  endtask

  task automatic test_miss();
    imem_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        imem_done = 1'b1;
        imem_data = mem_word(imem_addr, halt_addr);
      end
      #1;
      checks++; if (imem_addr !== 16'h0004 || imem_rd !== 1'b1) begin errors++; $display("[TB] FAIL miss_hold_addr: got rd=%b addr=%h expected rd=1 addr=0004", imem_rd, imem_addr); end
      if (k == 1) begin
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL miss_bubble: got %b expected 0", if_valid); end
      end
      tick();
    end
    imem_done = 1'b0;
    checks++; if (if_instr !== 16'h8004 || if_pc_plus2 !== 16'h0006 || if_valid !== 1'b1) begin errors++; $display("[TB] FAIL miss_deliver: got %h/%h/%b expected 8004/0006/1", if_instr, if_pc_plus2, if_valid); end
    imem_done = 1'b1;
    imem_data = mem_word(imem_addr, halt_addr);
    #1;
    checks++; if (imem_addr !== 16'h0006) begin errors++; $display("[TB] FAIL miss_next_addr: got %h expected 0006", imem_addr); end
    tick();
    imem_done = 1'b0;
    checks++; if (if_pc_plus2 !== 16'h0008) begin errors++; $display("[TB] FAIL after_miss_pc2: got %h expected 0008", if_pc_plus2); end
  endtask

  task automatic test_hold_skid();
    hold      = 1'b0;
    imem_done = 1'b0;
    #1;
    checks++; if (imem_addr !== 16'h0008) begin errors++; $display("[TB] FAIL skid_addr: got %h expected 0008", imem_addr); end
    tick();
    hold = 1'b1;
    tick();
    imem_done = 1'b1;
    imem_data = mem_word(imem_addr, halt_addr);
    tick();
    imem_done = 1'b0;
    checks++; if (if_valid !== 1'b0 || if_instr !== 16'h0800 || if_pc_plus2 !== 16'h0008) begin errors++; $display("[TB] FAIL hold_frozen: got %h/%h/%b expected 0800/0008/0", if_instr, if_pc_plus2, if_valid); end
    checks++; if (dut.sb_valid !== 1'b1) begin errors++; $display("[TB] FAIL skid_loaded: got %b expected 1", dut.sb_valid); end
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("[TB] FAIL hold_no_req: got %b expected 0", imem_rd); end
    hold = 1'b0;
    #1;
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("[TB] FAIL drain_no_req: got %b expected 0", imem_rd); end
    tick();
    checks++; if (if_instr !== 16'h8008 || if_pc_plus2 !== 16'h000A || if_valid !== 1'b1) begin errors++; $display("[TB] FAIL skid_drain: got %h/%h/%b expected 8008/000a/1", if_instr, if_pc_plus2, if_valid); end
    checks++; if (imem_addr !== 16'h000A || imem_rd !== 1'b1) begin errors++; $display("[TB] FAIL after_drain_req: got rd=%b addr=%h expected rd=1 addr=000a", imem_rd, imem_addr); end
  endtask

  task automatic test_redirect_discard();
    imem_done = 1'b0;
    tick();
    redirect_en = 1'b1;
    redirect_pc = 16'h0041;
    tick();
    redirect_en = 1'b0;
    #1;
    checks++; if (imem_addr !== 16'h000A || imem_rd !== 1'b1) begin errors++; $display("[TB] FAIL discard_stable: got rd=%b addr=%h expected rd=1 addr=000a", imem_rd, imem_addr); end
    checks++; if (if_valid !== 1'b0 || if_instr !== 16'h0800) begin errors++; $display("[TB] FAIL redirect_flush: got %h/%b expected 0800/0", if_instr, if_valid); end
    imem_done = 1'b1;
    imem_data = mem_word(imem_addr, halt_addr);
    tick();
    imem_done = 1'b0;
    checks++; if (if_valid !== 1'b0 || if_instr !== 16'h0800) begin errors++; $display("[TB] FAIL discard_drop: got %h/%b expected 0800/0", if_instr, if_valid); end
    checks++; if (imem_addr !== 16'h0040 || imem_rd !== 1'b1) begin errors++; $display("[TB] FAIL redirect_target: got rd=%b addr=%h expected rd=1 addr=0040", imem_rd, imem_addr); end
  endtask

  task automatic test_halt();
    redirect_en = 1'b1;
    redirect_pc = 16'h000C;
    imem_done   = 1'b1;
    imem_data   = mem_word(imem_addr, halt_addr);
    tick();
    redirect_en = 1'b0;
    imem_done   = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem_addr !== 16'h000C) begin errors++; $display("[TB] FAIL redirect_hit_drop: got valid=%b addr=%h expected 0/000c", if_valid, imem_addr); end
    halt_addr = 16'h000C;
    imem_done = 1'b1;
    imem_data = mem_word(imem_addr, halt_addr);
    tick();
    imem_done = 1'b0;
    checks++; if (halted !== 1'b1 || if_instr !== 16'h0000 || if_valid !== 1'b1 || if_pc_plus2 !== 16'h000E) begin errors++; $display("[TB] FAIL halt_enter: got halted=%b %h/%b/%h expected 1 0000/1/000e", halted, if_instr, if_valid, if_pc_plus2); end
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (imem_rd !== 1'b0) begin errors++; $display("[TB] FAIL halt_idle_rd: cycle %0d got %b expected 0", c, imem_rd); end
      tick();
    end
    checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_sticky: got %b expected 1", halted); end
    redirect_en = 1'b1;
    redirect_pc = 16'h0020;
    tick();
    redirect_en = 1'b0;
    #1;
    checks++; if (halted !== 1'b0 || imem_addr !== 16'h0020 || imem_rd !== 1'b1) begin errors++; $display("[TB] FAIL halt_resume: got halted=%b rd=%b addr=%h expected 0/1/0020", halted, imem_rd, imem_addr); end
    imem_done = 1'b1;
    imem_data = mem_word(imem_addr, halt_addr);
    tick();
    imem_done = 1'b0;
    checks++; if (if_instr !== 16'h8020 || if_valid !== 1'b1) begin errors++; $display("[TB] FAIL resume_fetch: got %h/%b expected 8020/1", if_instr, if_valid); end
  endtask

  task automatic test_wrap_priority();
    hold        = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 16'hFFFE;
    #1;
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("[TB] FAIL hold_redirect_rd: got %b expected 0", imem_rd); end
    tick();
    redirect_en = 1'b0;
    checks++; if (if_valid !== 1'b0 || if_instr !== 16'h0800 || imem_addr !== 16'hFFFE) begin errors++; $display("[TB] FAIL redirect_beats_hold: got %h/%b addr=%h expected 0800/0 fffe", if_instr, if_valid, imem_addr); end
    hold      = 1'b0;
    imem_done = 1'b1;
    imem_data = mem_word(imem_addr, halt_addr);
    #1;
    checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'hFFFE) begin errors++; $display("[TB] FAIL wrap_req: got rd=%b addr=%h expected 1/fffe", imem_rd, imem_addr); end
    tick();
    imem_done = 1'b0;
    checks++; if (if_instr !== 16'hFFFE || if_pc_plus2 !== 16'h0000 || if_valid !== 1'b1) begin errors++; $display("[TB] FAIL wrap_deliver: got %h/%h/%b expected fffe/0000/1", if_instr, if_pc_plus2, if_valid); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_next_addr: got %h expected 0000", imem_addr); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    hold        = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 16'h0000;
    imem_data   = 16'h0000;
    imem_done   = 1'b0;
    halt_addr   = 16'h1111;

    test_reset();
    test_hits();
    test_miss();
    test_hold_skid();
    test_redirect_discard();
    test_halt();
    test_wrap_priority();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
